cpu_state_regs: RTL and testbench
=================================

Name: cpu_state_regs

Overview:
- Parametrised architectural register bank for the accumulator CPU: PC, IR, ACC, MDR, MAR and zflag.
- Adds per-register write enables, PC auto-increment, a global stall, and a LIFO context stack.
- The context stack saves and restores PC/ACC/zflag for interrupt entry and return.
- Sits between the control FSM/datapath muxes and the memory interface; the datapath reads its outputs every cycle.

Parameters:
- DATA_W, 16: width of IR, ACC, MDR.
- ADDR_W, 8: width of PC, MAR.
- CTX_DEPTH, 4: number of context-stack entries (power of two, >=2).
- LVL_W, $clog2(CTX_DEPTH)+1: width of ctx_level.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  freezes all state updates.
- pc_we  in  1  load PC from pc_next.
- pc_inc  in  1  PC <= PC+1.
- pc_next  in  ADDR_W  PC load value.
- ir_we  in  1  IR write enable.
- ir_next  in  DATA_W  IR load value.
- acc_we  in  1  ACC write enable.
- acc_next  in  DATA_W  ACC load value.
- mdr_we  in  1  MDR write enable.
- mdr_next  in  DATA_W  MDR load value.
- mar_we  in  1  MAR write enable.
- mar_next  in  ADDR_W  MAR load value.
- zflag_we  in  1  zflag write enable.
- zflag_next  in  1  zflag load value.
- ctx_push  in  1  save {PC,ACC,zflag} to the stack.
- ctx_pop  in  1  restore {PC,ACC,zflag} from the stack.
- PC_reg  out  ADDR_W  program counter.
- IR_reg  out  DATA_W  instruction register.
- ACC_reg  out  DATA_W  accumulator.
- MDR_reg  out  DATA_W  memory data register.
- MAR_reg  out  ADDR_W  memory address register.
- zflag_reg  out  1  zero flag.
- ctx_level  out  LVL_W  number of occupied stack entries.
- ctx_full  out  1  ctx_level==CTX_DEPTH.
- ctx_empty  out  1  ctx_level==0.
- ctx_err  out  1  sticky stack-misuse flag.

Behaviour:
- Reset:
  - All registers update only on posedge clk.
  - rst==0 at an edge clears every output register, ctx_level and ctx_err to 0. ctx_empty=1, ctx_full=0.
  - Stack contents are not cleared and are don't-care.
  - Reset overrides stall, push and pop. Reset mid-interrupt discards all saved contexts.
- Stall:
  - stall=1 holds every register, the stack and ctx_err unchanged, regardless of other inputs.
- Writes:
  - Each register loads its *_next on its *_we. Registers without an active enable hold.
  - Write latency is 1 cycle: the new value is visible on the output the cycle after the enable.
- PC:
  - pc_we has priority over pc_inc.
  - pc_inc adds 1 modulo 2^ADDR_W, so 0xFF wraps to 0x00 for ADDR_W=8.
- Push (ctx_push=1, ctx_pop=0, not full):
  - Stores the current pre-edge {PC_reg,ACC_reg,zflag_reg} at entry ctx_level. ctx_level increments.
  - Same-cycle register writes still apply normally.
- Pop (ctx_pop=1, ctx_push=0, not empty):
  - Loads PC, ACC and zflag from entry ctx_level-1. ctx_level decrements.
  - The pop overrides pc_we, pc_inc, acc_we and zflag_we in that cycle.
  - IR, MDR and MAR writes still apply.
- Error cases (set ctx_err=1; stack and ctx_level unchanged; normal register writes still apply):
  - Push when full.
  - Pop when empty.
  - ctx_push and ctx_pop asserted together.
- ctx_err is cleared only by reset.
- ctx_full, ctx_empty and ctx_level are registered-state derived and have no combinational path from the inputs.
- No combinational input-to-output paths anywhere in the block.

Optional Feature:
- Macro: CPU_STATE_ZFLAG_AUTO_EN.
- Defined:
  - Whenever ACC is loaded by acc_we, zflag is loaded with (acc_next==0) in the same edge.
  - zflag_we and zflag_next are ignored; the ports remain present.
  - A pop still restores the saved zflag.
- Undefined: zflag changes only via zflag_we or pop, as described above.

Test Plan:
- Reset: drive all *_we=1 with nonzero *_next, hold rst=0 for one edge -> all outputs 0, ctx_empty=1, ctx_err=0.
- PC wrap: pc_we with pc_next=0xFE, then pc_inc for 2 cycles -> PC_reg 0xFF then 0x00. Assert pc_we with 0x10 and pc_inc together -> PC_reg=0x10.
- Stall: PC=0x05, stall=1 with pc_inc, acc_we and ctx_push all active for 3 cycles -> all outputs and ctx_level unchanged.
- Push/pop: PC=0x20, ACC=0x1234, zflag=1.
  - Push with the same-cycle acc_we of 0x0000 -> ACC=0x0000, ctx_level=1.
  - Pop with acc_we=0xBEEF in the same cycle -> PC=0x20, ACC=0x1234, zflag=1, ctx_level=0.
- Stack bounds: push CTX_DEPTH times -> ctx_full=1.
  - Push again -> ctx_err=1, ctx_level=4.
  - Pop 4 times -> LIFO order restored, ctx_empty=1.
  - Pop again -> ctx_err stays 1, ctx_level=0.
  - Push and pop asserted together -> no stack change.
- With CPU_STATE_ZFLAG_AUTO_EN: acc_we with 0x0000 while zflag_we=1, zflag_next=0 -> zflag=1. acc_we with 0x0001 -> zflag=0. Without the macro, the same stimulus gives zflag=0 on the first write and zflag unchanged on the second.

Source files
------------

// File: rtl/cpu_state_regs_if.sv
// Bus bundle between the control FSM/datapath muxes and the CPU register bank.
// The master drives the enables, load values and stack controls. The slave
// (cpu_state_regs) returns the architectural register values and stack status.
interface cpu_state_regs_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int CTX_DEPTH = 4,
    parameter int LVL_W     = $clog2(CTX_DEPTH) + 1
);
    logic              stall;
    logic              pc_we;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              ir_we;
    logic [DATA_W-1:0] ir_next;
    logic              acc_we;
    logic [DATA_W-1:0] acc_next;
    logic              mdr_we;
    logic [DATA_W-1:0] mdr_next;
    logic              mar_we;
    logic [ADDR_W-1:0] mar_next;
    logic              zflag_we;
    logic              zflag_next;
    logic              ctx_push;
    logic              ctx_pop;

    logic [ADDR_W-1:0] PC_reg;
    logic [DATA_W-1:0] IR_reg;
    logic [DATA_W-1:0] ACC_reg;
    logic [DATA_W-1:0] MDR_reg;
    logic [ADDR_W-1:0] MAR_reg;
    logic              zflag_reg;
    logic [LVL_W-1:0]  ctx_level;
    logic              ctx_full;
    logic              ctx_empty;
    logic              ctx_err;

    modport master (
        output stall, pc_we, pc_inc, pc_next, ir_we, ir_next, acc_we, acc_next,
               mdr_we, mdr_next, mar_we, mar_next, zflag_we, zflag_next,
               ctx_push, ctx_pop,
        input  PC_reg, IR_reg, ACC_reg, MDR_reg, MAR_reg, zflag_reg,
               ctx_level, ctx_full, ctx_empty, ctx_err
    );

    modport slave (
        input  stall, pc_we, pc_inc, pc_next, ir_we, ir_next, acc_we, acc_next,
               mdr_we, mdr_next, mar_we, mar_next, zflag_we, zflag_next,
               ctx_push, ctx_pop,
        output PC_reg, IR_reg, ACC_reg, MDR_reg, MAR_reg, zflag_reg,
               ctx_level, ctx_full, ctx_empty, ctx_err
    );
endinterface

// File: rtl/cpu_state_regs.sv
// Architectural register bank for the accumulator CPU: PC, IR, ACC, MDR, MAR,
// zflag, plus a LIFO context stack saving {PC, ACC, zflag} for interrupts.
// Optional build macro CPU_STATE_ZFLAG_AUTO_EN: zflag follows (acc_next == 0)
// on every ACC load and the zflag_we/zflag_next inputs are ignored.
module cpu_state_regs #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int CTX_DEPTH = 4,
    parameter int LVL_W     = $clog2(CTX_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    cpu_state_regs_if.slave bus
);
    localparam int PTR_W = $clog2(CTX_DEPTH);
    localparam int CTX_W = ADDR_W + DATA_W + 1;

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] ir_q,    ir_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic [DATA_W-1:0] mdr_q,   mdr_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic              zflag_q, zflag_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q,   err_d;
    logic [CTX_W-1:0]  stack_q [CTX_DEPTH];
    logic [CTX_W-1:0]  stack_d [CTX_DEPTH];

    logic              full, empty;
    logic              push_ok, pop_ok, misuse;
    logic [PTR_W-1:0]  wr_idx, rd_idx;

    assign full   = (level_q == LVL_W'(CTX_DEPTH));
    assign empty  = (level_q == '0);
    assign wr_idx = level_q[PTR_W-1:0];
    assign rd_idx = PTR_W'(level_q - LVL_W'(1));

`ifdef CPU_STATE_ZFLAG_AUTO_EN
    logic unused_zflag_in;
    assign unused_zflag_in = ^{bus.zflag_we, bus.zflag_next};
`endif

    // Next-state for every register and the stack; stall freezes everything.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        mdr_d   = mdr_q;
        mar_d   = mar_q;
        zflag_d = zflag_q;
        level_d = level_q;
        err_d   = err_q;
        stack_d = stack_q;
        push_ok = bus.ctx_push && !bus.ctx_pop && !full;
        pop_ok  = bus.ctx_pop && !bus.ctx_push && !empty;
        misuse  = (bus.ctx_push && bus.ctx_pop) || (bus.ctx_push && full) ||
                  (bus.ctx_pop && empty);

        if (!bus.stall) begin
            if (bus.pc_we) begin
                pc_d = bus.pc_next;
            end else if (bus.pc_inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (bus.ir_we)  ir_d  = bus.ir_next;
            if (bus.acc_we) acc_d = bus.acc_next;
            if (bus.mdr_we) mdr_d = bus.mdr_next;
            if (bus.mar_we) mar_d = bus.mar_next;
`ifdef CPU_STATE_ZFLAG_AUTO_EN
            if (bus.acc_we) zflag_d = (bus.acc_next == '0);
`else
            if (bus.zflag_we) zflag_d = bus.zflag_next;
`endif
            if (misuse) err_d = 1'b1;

            // Push saves the pre-edge values; same-cycle writes above still land.
            if (push_ok) begin
                stack_d[wr_idx] = {pc_q, acc_q, zflag_q};
                level_d         = level_q + LVL_W'(1);
            end

            // Pop wins over any PC/ACC/zflag update in the same cycle.
            if (pop_ok) begin
                {pc_d, acc_d, zflag_d} = stack_q[rd_idx];
                level_d                = level_q - LVL_W'(1);
            end
        end
    end

    // Architectural state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            mdr_q   <= '0;
            mar_q   <= '0;
            zflag_q <= 1'b0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            mdr_q   <= mdr_d;
            mar_q   <= mar_d;
            zflag_q <= zflag_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack storage is never reset; entries above ctx_level are don't-care.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.PC_reg    = pc_q;
    assign bus.IR_reg    = ir_q;
    assign bus.ACC_reg   = acc_q;
    assign bus.MDR_reg   = mdr_q;
    assign bus.MAR_reg   = mar_q;
    assign bus.zflag_reg = zflag_q;
    assign bus.ctx_level = level_q;
    assign bus.ctx_full  = full;
    assign bus.ctx_empty = empty;
    assign bus.ctx_err   = err_q;
endmodule

// File: tb/tb_cpu_state_regs.sv
// Directed-vector bench for cpu_state_regs. Expected zflag values depend on
// whether CPU_STATE_ZFLAG_AUTO_EN is defined for the build.
module tb_cpu_state_regs;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int CTX_DEPTH = 4;
    localparam int LVL_W     = $clog2(CTX_DEPTH) + 1;
`ifdef CPU_STATE_ZFLAG_AUTO_EN
    localparam bit Z_AUTO = 1'b1;
`else
    localparam bit Z_AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    cpu_state_regs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTX_DEPTH(CTX_DEPTH),
                        .LVL_W(LVL_W)) bus_if ();

    cpu_state_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTX_DEPTH(CTX_DEPTH),
                     .LVL_W(LVL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus_if.stall      = 1'b0;
        bus_if.pc_we      = 1'b0;
        bus_if.pc_inc     = 1'b0;
        bus_if.pc_next    = '0;
        bus_if.ir_we      = 1'b0;
        bus_if.ir_next    = '0;
        bus_if.acc_we     = 1'b0;
        bus_if.acc_next   = '0;
        bus_if.mdr_we     = 1'b0;
        bus_if.mdr_next   = '0;
        bus_if.mar_we     = 1'b0;
        bus_if.mar_next   = '0;
        bus_if.zflag_we   = 1'b0;
        bus_if.zflag_next = 1'b0;
        bus_if.ctx_push   = 1'b0;
        bus_if.ctx_pop    = 1'b0;
    endtask

    // One clock edge, then sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctx(input string tag, input int lvl, input bit err);
        check({tag, "_lvl"},   32'(bus_if.ctx_level), 32'(lvl));
        check({tag, "_full"},  32'(bus_if.ctx_full),  32'(lvl == CTX_DEPTH));
        check({tag, "_empty"}, 32'(bus_if.ctx_empty), 32'(lvl == 0));
        check({tag, "_err"},   32'(bus_if.ctx_err),   32'(err));
    endtask

    initial begin
        logic z_exp;
        logic z_saved;

        // Reset overrides every write enable and a push.
        clear_in();
        rst = 1'b0;
        bus_if.pc_we = 1'b1;  bus_if.pc_next = 8'h5A;
        bus_if.ir_we = 1'b1;  bus_if.ir_next = 16'hAAAA;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h5555;
        bus_if.mdr_we = 1'b1; bus_if.mdr_next = 16'h1111;
        bus_if.mar_we = 1'b1; bus_if.mar_next = 8'h22;
        bus_if.zflag_we = 1'b1; bus_if.zflag_next = 1'b1;
        bus_if.ctx_push = 1'b1;
        step();
        check("rst_pc",  32'(bus_if.PC_reg),    32'h0);
        check("rst_ir",  32'(bus_if.IR_reg),    32'h0);
        check("rst_acc", 32'(bus_if.ACC_reg),   32'h0);
        check("rst_mdr", 32'(bus_if.MDR_reg),   32'h0);
        check("rst_mar", 32'(bus_if.MAR_reg),   32'h0);
        check("rst_z",   32'(bus_if.zflag_reg), 32'h0);
        check_ctx("rst", 0, 1'b0);
        clear_in();
        rst = 1'b1;

        // PC load, increment with wrap, load priority over increment.
        bus_if.pc_we = 1'b1; bus_if.pc_next = 8'hFE;
        step();
        check("pc_load", 32'(bus_if.PC_reg), 32'hFE);
        clear_in(); bus_if.pc_inc = 1'b1;
        step();
        check("pc_inc_ff", 32'(bus_if.PC_reg), 32'hFF);
        step();
        check("pc_wrap", 32'(bus_if.PC_reg), 32'h00);
        bus_if.pc_we = 1'b1; bus_if.pc_next = 8'h10;
        step();
        check("pc_we_prio", 32'(bus_if.PC_reg), 32'h10);

        // IR/MDR/MAR loads, then hold with enables low.
        clear_in();
        bus_if.ir_we = 1'b1;  bus_if.ir_next = 16'hA5A5;
        bus_if.mdr_we = 1'b1; bus_if.mdr_next = 16'h5A5A;
        bus_if.mar_we = 1'b1; bus_if.mar_next = 8'h33;
        step();
        check("ir_load",  32'(bus_if.IR_reg),  32'hA5A5);
        check("mdr_load", 32'(bus_if.MDR_reg), 32'h5A5A);
        check("mar_load", 32'(bus_if.MAR_reg), 32'h33);
        clear_in();
        bus_if.ir_next = 16'h0000; bus_if.mdr_next = 16'hFFFF; bus_if.mar_next = 8'h00;
        step();
        check("ir_hold",  32'(bus_if.IR_reg),  32'hA5A5);
        check("mdr_hold", 32'(bus_if.MDR_reg), 32'h5A5A);
        check("mar_hold", 32'(bus_if.MAR_reg), 32'h33);
        check("pc_hold",  32'(bus_if.PC_reg),  32'h10);

        // Stall freezes PC, ACC and the stack for 3 cycles.
        clear_in();
        bus_if.pc_we = 1'b1;  bus_if.pc_next = 8'h05;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h1111;
        step();
        check("pre_stall_pc",  32'(bus_if.PC_reg),  32'h05);
        check("pre_stall_acc", 32'(bus_if.ACC_reg), 32'h1111);
        clear_in();
        bus_if.stall = 1'b1; bus_if.pc_inc = 1'b1;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h7777;
        bus_if.ctx_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",  32'(bus_if.PC_reg),    32'h05);
            check("stall_acc", 32'(bus_if.ACC_reg),   32'h1111);
            check("stall_lvl", 32'(bus_if.ctx_level), 32'h0);
        end

        // Push with same-cycle writes, then pop that overrides PC/ACC/zflag.
        clear_in();
        bus_if.pc_we = 1'b1;  bus_if.pc_next = 8'h20;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h1234;
        bus_if.zflag_we = 1'b1; bus_if.zflag_next = 1'b1;
        step();
        z_saved = Z_AUTO ? 1'b0 : 1'b1;
        check("setup_z", 32'(bus_if.zflag_reg), 32'(z_saved));
        clear_in();
        bus_if.ctx_push = 1'b1;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h0000;
        bus_if.pc_inc = 1'b1;
        step();
        check("push_acc", 32'(bus_if.ACC_reg), 32'h0000);
        check("push_pc",  32'(bus_if.PC_reg),  32'h21);
        check_ctx("push1", 1, 1'b0);
        clear_in();
        bus_if.ctx_pop = 1'b1;
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'hBEEF;
        bus_if.pc_we = 1'b1;  bus_if.pc_next = 8'h77;
        bus_if.zflag_we = 1'b1; bus_if.zflag_next = ~z_saved;
        bus_if.mdr_we = 1'b1; bus_if.mdr_next = 16'h0F0F;
        step();
        check("pop_pc",  32'(bus_if.PC_reg),    32'h20);
        check("pop_acc", 32'(bus_if.ACC_reg),   32'h1234);
        check("pop_z",   32'(bus_if.zflag_reg), 32'(z_saved));
        check("pop_mdr", 32'(bus_if.MDR_reg),   32'h0F0F);
        check_ctx("pop1", 0, 1'b0);

        // Fill the stack with distinct contexts.
        for (int i = 0; i < CTX_DEPTH; i++) begin
            clear_in();
            bus_if.pc_we = 1'b1;  bus_if.pc_next = 8'(8'h40 + i);
            bus_if.acc_we = 1'b1; bus_if.acc_next = 16'(16'h1000 + i);
            bus_if.zflag_we = 1'b1; bus_if.zflag_next = i[0];
            step();
            clear_in();
            bus_if.ctx_push = 1'b1;
            step();
        end
        check_ctx("fill", CTX_DEPTH, 1'b0);
        clear_in(); bus_if.ctx_push = 1'b1;
        step();
        check_ctx("overflow", CTX_DEPTH, 1'b1);

        // Drain in LIFO order.
        for (int i = CTX_DEPTH - 1; i >= 0; i--) begin
            clear_in(); bus_if.ctx_pop = 1'b1;
            step();
            z_exp = Z_AUTO ? 1'b0 : i[0];
            check("lifo_pc",  32'(bus_if.PC_reg),    32'(8'h40 + i));
            check("lifo_acc", 32'(bus_if.ACC_reg),   32'(16'h1000 + i));
            check("lifo_z",   32'(bus_if.zflag_reg), 32'(z_exp));
            check("lifo_lvl", 32'(bus_if.ctx_level), 32'(i));
        end
        check_ctx("drained", 0, 1'b1);
        clear_in(); bus_if.ctx_pop = 1'b1;
        step();
        check_ctx("underflow", 0, 1'b1);
        check("underflow_pc", 32'(bus_if.PC_reg), 32'h40);

        // Reset mid-interrupt clears ctx_err and discards saved contexts.
        clear_in(); bus_if.ctx_push = 1'b1;
        step();
        check("pre_rst_lvl", 32'(bus_if.ctx_level), 32'h1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_ctx("rst2", 0, 1'b0);

        // Simultaneous push and pop: error, no stack change, registers untouched.
        clear_in();
        bus_if.pc_we = 1'b1; bus_if.pc_next = 8'h66;
        step();
        clear_in(); bus_if.ctx_push = 1'b1;
        step();
        check_ctx("one_deep", 1, 1'b0);
        clear_in();
        bus_if.pc_we = 1'b1; bus_if.pc_next = 8'h99;
        step();
        clear_in(); bus_if.ctx_push = 1'b1; bus_if.ctx_pop = 1'b1;
        step();
        check_ctx("push_pop", 1, 1'b1);
        check("push_pop_pc", 32'(bus_if.PC_reg), 32'h99);

        // zflag behaviour with ACC loads.
        clear_in();
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h0000;
        bus_if.zflag_we = 1'b1; bus_if.zflag_next = 1'b0;
        step();
        check("zauto_zero", 32'(bus_if.zflag_reg), 32'(Z_AUTO ? 1'b1 : 1'b0));
        clear_in();
        bus_if.acc_we = 1'b1; bus_if.acc_next = 16'h0001;
        step();
        check("zauto_nonzero", 32'(bus_if.zflag_reg), 32'h0);
        check("zauto_acc",     32'(bus_if.ACC_reg),   32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
